ad9361_spi_master: RTL and testbench
====================================

Name: ad9361_spi_master

Overview:
Bit-level 4-wire SPI master for the AD9361 register port, driven directly by the register-sequencing controller. It accepts one single-byte register write or read per handshake and serialises a 24-bit frame: a 16-bit instruction followed by 8 data bits. It returns read data with a one-cycle valid pulse. It holds a busy flag from acceptance until the inter-frame gap has elapsed.

Parameters:
CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range 2..255
CS_SETUP, 2, sys_clk cycles from CS falling to first SCLK rising edge
CS_HOLD, 2, sys_clk cycles from last SCLK falling edge to CS rising
CS_GAP, 4, minimum sys_clk cycles CS stays high between frames

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous, active-high reset
ad9361_reg_addr  in  10  register address
ad9361_reg_data_in  in  8  write data
ad9361_reg_data_in_en  in  1  request; level-sampled in IDLE only
ad9361_reg_wr_rdn  in  1  1 = write, 0 = read
ad9361_reg_data_out  out  8  last read byte
ad9361_reg_data_out_en  out  1  one-cycle pulse, read data valid
ad9361_spi_busy  out  1  transaction in progress
ad9361_spi_cs  out  1  chip select, active low
ad9361_spi_sclk  out  1  SPI clock, idle low
ad9361_spi_mosi  out  1  serial data to device
ad9361_spi_miso  in  1  serial data from device

Behaviour:
- Clocking: single clock sys_clk. sys_rst is synchronous and active-high.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, data_out=8'h00, data_out_en=0. State goes to IDLE and all counters clear.
- Reset mid-frame: abort on the next edge. CS goes high immediately with no hold time, and no data_out_en pulse is issued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - If data_in_en=1, latch addr, data_in and wr_rdn on that edge, then go to SETUP.
  - busy=1 and cs=0 from the next cycle.
  - Inputs are ignored outside IDLE.
  - en held high across a whole frame does not retrigger until the block is back in IDLE.
  - The upstream controller must drop en once it sees busy.
- Frame layout, MSB first: {wr_rdn, 3'b000 (byte count - 1), 2'b00, addr[9:0], data[7:0]}.
  - For reads, MOSI is driven 0 during the data byte.
- SETUP: lasts CS_SETUP cycles, with MOSI = frame bit 23.
- SHIFT: 24 SCLK periods, each a CLK_DIV-cycle low half then a CLK_DIV-cycle high half.
  - MOSI updates only at the start of each low half; the device samples on SCLK rising.
  - MISO is sampled on the sys_clk edge that drives SCLK high, for bits 7..0 of the data phase.
- HOLD: SCLK low for CS_HOLD cycles, then CS goes high.
- GAP: CS high for CS_GAP cycles, then busy=0.
  - For reads: data_out is updated and data_out_en pulses in the first GAP cycle.
  - For writes: no data_out_en pulse.
- data_out holds its value until the next completed read.
- Timing with default parameters:
  - CS low = CS_SETUP + 48*CLK_DIV + CS_HOLD = 196 cycles.
  - busy high = 200 cycles.
  - Earliest next acceptance is the cycle busy reads 0.
- Counters are sized for CLK_DIV=255 with no wrap. The bit counter counts 23 down to 0; it terminates at 0 and never wraps.

Optional Feature:
Macro AD9361_SPI_RDBK_EN.
- Defined:
  - Every write is followed automatically by a read of the same address.
  - A full CS_GAP separates the two frames, and busy stays high across both.
  - The readback byte is compared with the written byte; data_out is not updated and data_out_en is not pulsed.
  - Extra output ad9361_spi_wr_err (1 bit, reset 0) is set on mismatch. It is cleared when the next write is accepted.
  - The flag is informational only; self-clearing registers may flag, and the sequence is never stalled.
- Undefined: the port is absent, and a write is a single frame.

Test Plan:
- Write addr 0x3DF, data 0x01, CLK_DIV=4 -> MOSI bitstream 0x83DF01 sampled on SCLK rising; cs low 196 cycles; busy 200 cycles; no data_out_en.
- Read addr 0x037 with MISO model returning 0x0A -> instruction 0x0037; data_out=0x0A with a single data_out_en pulse in the first GAP cycle; MOSI=0 during the data byte.
- Hold data_in_en=1 for 300 cycles from IDLE -> first frame; second frame starts only after busy falls; exactly two frames, CS high ≥4 cycles between them.
- Assert sys_rst at bit 10 of SHIFT -> next cycle cs=1, sclk=0, busy=0; no data_out_en; a fresh read afterwards completes correctly.
- CLK_DIV=2, CS_SETUP=1 -> SCLK period 4 cycles; CS low = 1 + 96 + 2 = 99 cycles.
- With AD9361_SPI_RDBK_EN, write 0x3F5 with 0x55 and a model returning 0x54 -> two frames under one busy; wr_err=1; next write with matching readback -> wr_err=0.

Source files
------------

// File: rtl/ad9361_spi_master.sv
// ad9361_spi_master: bit-level 4-wire SPI master for single-byte AD9361 register reads and writes
//
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   ad9361_reg_addr[9:0]             register address, latched on acceptance
//   ad9361_reg_data_in[7:0]          write data, latched on acceptance
//   ad9361_reg_data_in_en            request, sampled only while idle
//   ad9361_reg_wr_rdn                1 = write, 0 = read
//   ad9361_reg_data_out[7:0]         last read byte, held until the next completed read
//   ad9361_reg_data_out_en           one-cycle pulse in the first gap cycle of a read
//   ad9361_spi_busy                  high from acceptance until the inter-frame gap ends
//   ad9361_spi_cs/sclk/mosi/miso     SPI pins (cs active low, sclk idle low)
//   ad9361_spi_wr_err                readback mismatch flag (AD9361_SPI_RDBK_EN builds only)
//
// Build option: define AD9361_SPI_RDBK_EN to follow every write with a readback of the same
// address and flag mismatches on ad9361_spi_wr_err.
module ad9361_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [9:0] ad9361_reg_addr,
  input  logic [7:0] ad9361_reg_data_in,
  input  logic       ad9361_reg_data_in_en,
  input  logic       ad9361_reg_wr_rdn,
  output logic [7:0] ad9361_reg_data_out,
  output logic       ad9361_reg_data_out_en,
  output logic       ad9361_spi_busy,
  output logic       ad9361_spi_cs,
  output logic       ad9361_spi_sclk,
  output logic       ad9361_spi_mosi,
`ifdef AD9361_SPI_RDBK_EN
  output logic       ad9361_spi_wr_err,
`endif
  input  logic       ad9361_spi_miso
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [7:0] DIV_T   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_T = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_T  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_T   = 8'(CS_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        half_q, half_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic        wr_q, wr_d;
  logic        cs_q, cs_d, sclk_q, sclk_d, busy_q, busy_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
`ifdef AD9361_SPI_RDBK_EN
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rb_q, rb_d, err_q, err_d;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    half_d    = half_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    wr_d      = wr_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
`ifdef AD9361_SPI_RDBK_EN
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rb_d      = rb_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (ad9361_reg_data_in_en) begin
          state_d = SETUP;
          wr_d    = ad9361_reg_wr_rdn;
          // Reads shift zeros out during the data byte.
          frame_d = {ad9361_reg_wr_rdn, 5'b00000, ad9361_reg_addr,
                     ad9361_reg_wr_rdn ? ad9361_reg_data_in : 8'h00};
`ifdef AD9361_SPI_RDBK_EN
          addr_d  = ad9361_reg_addr;
          wdata_d = ad9361_reg_data_in;
          rb_d    = 1'b0;
          err_d   = ad9361_reg_wr_rdn ? 1'b0 : err_q;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_T) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          half_d  = 1'b0;
          bit_d   = 5'd23;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_T) begin
          cnt_d = 8'd0;
          if (!half_q) begin
            // This edge raises SCLK; capture MISO during the data byte.
            half_d = 1'b1;
            rx_d   = bit_q < 5'd8 ? {rx_q[6:0], ad9361_spi_miso} : rx_q;
          end else begin
            // End of a high half: next bit onto MOSI, or done after bit 0
            // (the final shift leaves MOSI low through HOLD).
            frame_d = {frame_q[22:0], 1'b0};
            half_d  = 1'b0;
            state_d = bit_q == 5'd0 ? HOLD : SHIFT;
            bit_d   = bit_q == 5'd0 ? bit_q : bit_q - 5'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_T) begin
          state_d   = GAP;
          cnt_d     = 8'd0;
          dout_en_d = !wr_q;
          dout_d    = wr_q ? dout_q : rx_q;
`ifdef AD9361_SPI_RDBK_EN
          err_d     = rb_q ? (rx_q != wdata_q) : err_q;
`endif
        end
      end
      GAP: begin
        if (cnt_q == GAP_T) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
`ifdef AD9361_SPI_RDBK_EN
          // A finished write frame chains straight into its readback frame.
          if (wr_q && !rb_q) begin
            state_d = SETUP;
            rb_d    = 1'b1;
            frame_d = {6'b000000, addr_q, 8'h00};
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    cs_d   = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    sclk_d = state_d == SHIFT && half_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      half_q    <= 1'b0;
      bit_q     <= 5'd0;
      frame_q   <= 24'd0;
      rx_q      <= 8'd0;
      wr_q      <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
`ifdef AD9361_SPI_RDBK_EN
      addr_q    <= 10'd0;
      wdata_q   <= 8'd0;
      rb_q      <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      wr_q      <= wr_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
`ifdef AD9361_SPI_RDBK_EN
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rb_q      <= rb_d;
      err_q     <= err_d;
`endif
    end
  end
  assign ad9361_reg_data_out    = dout_q;
  assign ad9361_reg_data_out_en = dout_en_q;
  assign ad9361_spi_busy        = busy_q;
  assign ad9361_spi_cs          = cs_q;
  assign ad9361_spi_sclk        = sclk_q;
  assign ad9361_spi_mosi        = frame_q[23];
`ifdef AD9361_SPI_RDBK_EN
  assign ad9361_spi_wr_err      = err_q;
`endif
endmodule

// File: tb/tb_ad9361_spi_master.sv
// tb_ad9361_spi_master: directed self-checking bench for ad9361_spi_master
module tb_ad9361_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [9:0] addr = '0;
  logic [7:0] din = '0;
  logic en = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [7:0] rd_byte = '0;
  logic miso;
  int rise_cnt = 0;
  logic [23:0] cap = '0;
  int errors = 0, checks = 0;
  logic [7:0] m_dout, f_dout;
  logic m_den, f_den, m_busy, f_busy, m_cs, f_cs, m_sclk, f_sclk, m_mosi, f_mosi;
`ifdef AD9361_SPI_RDBK_EN
  logic m_err, f_err;
`endif
  ad9361_spi_master u_dut (
    .sys_clk(clk), .sys_rst(rst), .ad9361_reg_addr(addr), .ad9361_reg_data_in(din),
    .ad9361_reg_data_in_en(en && !sel), .ad9361_reg_wr_rdn(wr),
    .ad9361_reg_data_out(m_dout), .ad9361_reg_data_out_en(m_den), .ad9361_spi_busy(m_busy),
    .ad9361_spi_cs(m_cs), .ad9361_spi_sclk(m_sclk), .ad9361_spi_mosi(m_mosi),
`ifdef AD9361_SPI_RDBK_EN
    .ad9361_spi_wr_err(m_err),
`endif
    .ad9361_spi_miso(miso));
  ad9361_spi_master #(.CLK_DIV(2), .CS_SETUP(1)) u_fast (
    .sys_clk(clk), .sys_rst(rst), .ad9361_reg_addr(addr), .ad9361_reg_data_in(din),
    .ad9361_reg_data_in_en(en && sel), .ad9361_reg_wr_rdn(wr),
    .ad9361_reg_data_out(f_dout), .ad9361_reg_data_out_en(f_den), .ad9361_spi_busy(f_busy),
    .ad9361_spi_cs(f_cs), .ad9361_spi_sclk(f_sclk), .ad9361_spi_mosi(f_mosi),
`ifdef AD9361_SPI_RDBK_EN
    .ad9361_spi_wr_err(f_err),
`endif
    .ad9361_spi_miso(miso));
  logic obs_cs, obs_sclk, obs_mosi, obs_busy, obs_den;
  logic [7:0] obs_dout;
  assign obs_cs   = sel ? f_cs : m_cs;
  assign obs_sclk = sel ? f_sclk : m_sclk;
  assign obs_mosi = sel ? f_mosi : m_mosi;
  assign obs_busy = sel ? f_busy : m_busy;
  assign obs_den  = sel ? f_den : m_den;
  assign obs_dout = sel ? f_dout : m_dout;
  // Device model: records MOSI on SCLK rising and presents rd_byte MSB first in the data phase.
  always @(negedge obs_cs or posedge obs_sclk)
    if (obs_sclk) begin
      rise_cnt <= rise_cnt + 1;
      cap <= {cap[22:0], obs_mosi};
    end else begin
      rise_cnt <= 0;
      cap <= '0;
    end
  always_comb miso = (rise_cnt >= 16 && rise_cnt < 24) && rd_byte[3'(23 - rise_cnt)];
  int n_busy, n_cs, n_hi, n_pulse;
  logic pulse_gap1, timeout;
  logic [7:0] pulse_data;
  task automatic do_frame(input logic w, input logic [9:0] a, input logic [7:0] d);
    int guard;
    logic prev_cs;
    addr = a; din = d; wr = w; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    n_busy = 0; n_cs = 0; n_hi = 0; n_pulse = 0; pulse_gap1 = 1'b0; pulse_data = '0;
    prev_cs = 1'b1; guard = 0;
    while (obs_busy && guard < 3000) begin
      n_busy++;
      if (!obs_cs) n_cs++;
      if (obs_sclk) n_hi++;
      if (obs_den) begin
        n_pulse++;
        pulse_gap1 = obs_cs && !prev_cs;
        pulse_data = obs_dout;
      end
      prev_cs = obs_cs;
      guard++;
      @(posedge clk); #1;
    end
    timeout = guard >= 3000;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (m_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", m_cs); end checks++;
    if (m_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", m_sclk); end checks++;
    if (m_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", m_mosi); end checks++;
    if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", m_busy); end checks++;
    if (m_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", m_dout); end checks++;
    if (m_den !== 1'b0) begin errors++; $display("FAIL reset_den got %b want 0", m_den); end checks++;
    if (f_cs !== 1'b1) begin errors++; $display("FAIL reset_fast_cs got %b want 1", f_cs); end checks++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_write();
`ifdef AD9361_SPI_RDBK_EN
    int exp_busy = 400, exp_cs = 392, exp_hi = 192;
    logic [23:0] exp_cap = 24'h03DF00;
`else
    int exp_busy = 200, exp_cs = 196, exp_hi = 96;
    logic [23:0] exp_cap = 24'h83DF01;
`endif
    sel = 1'b0; rd_byte = 8'h00;
    do_frame(1'b1, 10'h3DF, 8'h01);
    if (timeout !== 1'b0) begin errors++; $display("FAIL write_timeout busy never fell"); end checks++;
    if (cap !== exp_cap) begin errors++; $display("FAIL write_mosi got %h want %h", cap, exp_cap); end checks++;
    if (n_cs != exp_cs) begin errors++; $display("FAIL write_cs_low got %0d want %0d", n_cs, exp_cs); end checks++;
    if (n_busy != exp_busy) begin errors++; $display("FAIL write_busy got %0d want %0d", n_busy, exp_busy); end checks++;
    if (n_hi != exp_hi) begin errors++; $display("FAIL write_sclk_hi got %0d want %0d", n_hi, exp_hi); end checks++;
    if (n_pulse != 0) begin errors++; $display("FAIL write_pulse got %0d want 0", n_pulse); end checks++;
  endtask
  task automatic test_read();
    sel = 1'b0; rd_byte = 8'h0A;
    do_frame(1'b0, 10'h037, 8'hFF);
    if (cap !== 24'h003700) begin errors++; $display("FAIL read_mosi got %h want 003700", cap); end checks++;
    if (n_cs != 196) begin errors++; $display("FAIL read_cs_low got %0d want 196", n_cs); end checks++;
    if (n_busy != 200) begin errors++; $display("FAIL read_busy got %0d want 200", n_busy); end checks++;
    if (n_pulse != 1) begin errors++; $display("FAIL read_pulses got %0d want 1", n_pulse); end checks++;
    if (pulse_gap1 !== 1'b1) begin errors++; $display("FAIL read_pulse_pos got %b want 1", pulse_gap1); end checks++;
    if (pulse_data !== 8'h0A) begin errors++; $display("FAIL read_data got %h want 0a", pulse_data); end checks++;
    repeat (5) @(posedge clk);
    #1;
    if (m_dout !== 8'h0A) begin errors++; $display("FAIL read_hold got %h want 0a", m_dout); end checks++;
  endtask
  task automatic test_hold_en();
    int frames = 0, frames300 = 0, gap_run = 0, min_gap = 1000, guard = 0;
    logic prev_cs = 1'b1, prev_busy = 1'b0, idle_before_2nd = 1'b0;
    sel = 1'b0; rd_byte = 8'h5A; addr = 10'h155; wr = 1'b0; en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (prev_cs && !m_cs) begin
        frames++;
        if (frames == 2) begin
          idle_before_2nd = !prev_busy;
          min_gap = gap_run;
        end
      end
      gap_run = m_cs ? gap_run + 1 : 0;
      prev_cs = m_cs; prev_busy = m_busy;
    end
    frames300 = frames;
    en = 1'b0;
    while ((m_busy || !m_cs) && guard < 1000) begin
      @(posedge clk); #1;
      if (prev_cs && !m_cs) frames++;
      prev_cs = m_cs; guard++;
    end
    if (guard >= 1000) begin errors++; $display("FAIL hold_timeout busy never fell"); end checks++;
    if (frames300 != 2) begin errors++; $display("FAIL hold_frames300 got %0d want 2", frames300); end checks++;
    if (frames != 2) begin errors++; $display("FAIL hold_frames got %0d want 2", frames); end checks++;
    if (min_gap < 4) begin errors++; $display("FAIL hold_gap got %0d want >=4", min_gap); end checks++;
    if (idle_before_2nd !== 1'b1) begin errors++; $display("FAIL hold_retrigger got %b want 1", idle_before_2nd); end checks++;
  endtask
  task automatic test_reset_mid();
    int guard = 0, pulses = 0;
    sel = 1'b0; rd_byte = 8'h77; addr = 10'h100; wr = 1'b0; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    while (rise_cnt < 10 && guard < 1000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 1000) begin errors++; $display("FAIL mid_timeout bit 10 never reached"); end checks++;
    rst = 1'b1;
    @(posedge clk); #1;
    if (m_cs !== 1'b1) begin errors++; $display("FAIL mid_cs got %b want 1", m_cs); end checks++;
    if (m_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", m_sclk); end checks++;
    if (m_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", m_busy); end checks++;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_den) pulses++;
      @(posedge clk); #1;
    end
    if (pulses != 0) begin errors++; $display("FAIL mid_pulse got %0d want 0", pulses); end checks++;
    rd_byte = 8'hC3;
    do_frame(1'b0, 10'h2AA, 8'h00);
    if (cap !== 24'h02AA00) begin errors++; $display("FAIL mid_fresh_mosi got %h want 02aa00", cap); end checks++;
    if (pulse_data !== 8'hC3 || n_pulse != 1) begin errors++; $display("FAIL mid_fresh_data got %h x%0d want c3 x1", pulse_data, n_pulse); end checks++;
  endtask
  task automatic test_fast();
    sel = 1'b1; rd_byte = 8'h3C;
    do_frame(1'b0, 10'h123, 8'h00);
    if (n_cs != 99) begin errors++; $display("FAIL fast_cs_low got %0d want 99", n_cs); end checks++;
    if (n_busy != 103) begin errors++; $display("FAIL fast_busy got %0d want 103", n_busy); end checks++;
    if (n_hi != 48) begin errors++; $display("FAIL fast_sclk_hi got %0d want 48", n_hi); end checks++;
    if (cap !== 24'h012300) begin errors++; $display("FAIL fast_mosi got %h want 012300", cap); end checks++;
    if (pulse_data !== 8'h3C) begin errors++; $display("FAIL fast_data got %h want 3c", pulse_data); end checks++;
    sel = 1'b0;
  endtask
`ifdef AD9361_SPI_RDBK_EN
  task automatic test_readback();
    sel = 1'b0; rd_byte = 8'h54;
    do_frame(1'b1, 10'h3F5, 8'h55);
    if (n_busy != 400) begin errors++; $display("FAIL rdbk_busy got %0d want 400", n_busy); end checks++;
    if (n_pulse != 0) begin errors++; $display("FAIL rdbk_pulse got %0d want 0", n_pulse); end checks++;
    if (cap !== 24'h03F500) begin errors++; $display("FAIL rdbk_mosi got %h want 03f500", cap); end checks++;
    if (m_err !== 1'b1) begin errors++; $display("FAIL rdbk_err_set got %b want 1", m_err); end checks++;
    if (m_dout !== 8'hC3) begin errors++; $display("FAIL rdbk_dout got %h want c3", m_dout); end checks++;
    rd_byte = 8'h55;
    do_frame(1'b1, 10'h3F5, 8'h55);
    if (m_err !== 1'b0) begin errors++; $display("FAIL rdbk_err_clr got %b want 0", m_err); end checks++;
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_write();
    test_read();
    test_hold_en();
    test_reset_mid();
    test_fast();
`ifdef AD9361_SPI_RDBK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
